// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and instruction-fetch sequencer.
//
// Holds the PC and exports it through pc_out to an external PC+4 adder, which
// returns pc_plus4. Fetches one instruction at a time from instruction memory
// using a req/ready handshake. Holds the fetched word for decode until decode
// stops stalling, then advances the PC: to a redirect target if there is one,
// otherwise to pc_plus4.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   When defined, the block adds the misalign_err port and the TRAP_VECTOR
//   parameter. A redirect target with nonzero [1:0] then loads TRAP_VECTOR
//   instead of the target. When undefined, the low two bits of a redirect
//   target are cleared without any indication.
//
// Ports:
//   clock, reset               - rising-edge clock; asynchronous active-high reset
//   pc_out / pc_plus4          - PC to the adder and the adder result back
//   imem_req / imem_addr       - fetch request and its address (imem_addr = pc_out)
//   imem_ready / imem_rdata    - memory response
//   instr_out / instr_valid    - instruction held for decode
//   stall                      - decode cannot take instr_out this cycle
//   branch_taken/branch_target - branch redirect
//   jump / jump_target         - jump redirect (takes priority over branch)
//   misalign_err               - present only with PC_MISALIGN_TRAP_EN

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
`endif
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target
`ifdef PC_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic        pending;
    logic [31:0] pending_target;

    logic        fresh;
    logic [31:0] fresh_target;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] next_pc;
`ifdef PC_MISALIGN_TRAP_EN
    logic        target_misaligned;
`endif

    // The address is held stable for the whole request because the PC changes only in HOLD.
    assign imem_addr = pc_out;

    // Select the next PC. A fresh redirect in the release cycle takes priority over a pending one.
    always_comb begin
        fresh           = instr_valid & (jump | branch_taken);
        fresh_target    = jump ? jump_target : branch_target;
        redirect        = fresh | pending;
        redirect_target = fresh ? fresh_target : pending_target;
        next_pc         = redirect ? (redirect_target & 32'hFFFF_FFFC) : pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
        target_misaligned = redirect & (redirect_target[1:0] != 2'b00);
        if (target_misaligned) begin
            next_pc = TRAP_VECTOR;
        end
`endif
    end

    // Fetch sequencer with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            pc_out         <= RESET_PC;
            imem_req       <= 1'b0;
            instr_out      <= 32'h0;
            instr_valid    <= 1'b0;
            pending        <= 1'b0;
            pending_target <= 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_err   <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr_out   <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        // Remember the latest redirect until decode releases the instruction.
                        if (fresh) begin
                            pending        <= 1'b1;
                            pending_target <= fresh_target;
                        end
                    end else begin
                        pc_out      <= next_pc;
                        instr_valid <= 1'b0;
                        pending     <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= REQ;
`ifdef PC_MISALIGN_TRAP_EN
                        misalign_err <= target_misaligned;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl. It uses directed stimulus and a transaction-level
// reference model. It also includes literal checks that pin the model's values
// at key points in the sequence.

module tb_pc_fetch_ctrl;

    localparam logic [31:0] RDATA_XOR = 32'hA5A5_0000;
    localparam logic [31:0] TRAP      = 32'h0000_0080;

    logic        clock;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;

    pc_fetch_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target)
`ifdef PC_MISALIGN_TRAP_EN
        ,
        .misalign_err  (misalign_err)
`endif
    );

    // External adder and memory
    assign pc_plus4   = pc_out + 32'd4;
    assign imem_rdata = imem_addr ^ RDATA_XOR;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model. It tracks the fetch transaction in progress:
    // a one-cycle idle period, an outstanding request, or a held instruction.
    logic        m_idle  = 1'b1;
    logic        m_req   = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic        m_pend  = 1'b0;
    logic [31:0] m_ptgt  = 32'h0;
    logic        m_err   = 1'b0;

    always @(posedge clock or posedge reset) begin : model
        logic        have;
        logic        use_redir;
        logic [31:0] tgt;
        logic        err_next;
        if (reset) begin
            m_idle = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_pc = 32'h0;
            m_instr = 32'h0; m_pend = 1'b0; m_ptgt = 32'h0; m_err = 1'b0;
        end else begin
            err_next = 1'b0;
            if (m_idle) begin
                m_idle = 1'b0;
                m_req  = 1'b1;
            end else if (m_req) begin
                if (imem_ready) begin
                    m_instr = m_pc ^ RDATA_XOR;
                    m_valid = 1'b1;
                    m_req   = 1'b0;
                end
            end else begin
                have = jump | branch_taken;
                tgt  = jump ? jump_target : branch_target;
                if (stall) begin
                    if (have) begin
                        m_pend = 1'b1;
                        m_ptgt = tgt;
                    end
                end else begin
                    use_redir = 1'b1;
                    if (!have) begin
                        if (m_pend) tgt = m_ptgt;
                        else use_redir = 1'b0;
                    end
                    if (!use_redir) begin
                        m_pc = m_pc + 32'd4;
                    end else if (tgt[1:0] != 2'b00) begin
`ifdef PC_MISALIGN_TRAP_EN
                        m_pc = TRAP;
                        err_next = 1'b1;
`else
                        m_pc = {tgt[31:2], 2'b00};
`endif
                    end else begin
                        m_pc = tgt;
                    end
                    m_valid = 1'b0;
                    m_pend  = 1'b0;
                    m_req   = 1'b1;
                end
            end
            m_err = err_next;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT outputs with the model.
    task automatic cmp_all();
        chk("pc_out", pc_out, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("imem_req", 32'(imem_req), 32'(m_req));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) chk("instr_out", instr_out, m_instr);
`ifdef PC_MISALIGN_TRAP_EN
        chk("misalign_err", 32'(misalign_err), 32'(m_err));
`endif
    endtask

    // Advance one cycle and check the outputs 2 time units after the rising edge.
    task automatic step();
        @(posedge clock);
        #2;
        cmp_all();
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        step(); step();
        chk("rst_instr_out", instr_out, 32'h0);
        reset = 1'b0;
        #1;
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_pc", pc_out, 32'h0);

        // sequential fetch
        step(); chk("seq_addr0", imem_addr, 32'h0); chk("seq_req0", 32'(imem_req), 32'd1);
        step(); chk("seq_instr0", instr_out, 32'hA5A5_0000);
        step(); chk("seq_addr4", imem_addr, 32'h4);
        step(); chk("seq_instr4", instr_out, 32'hA5A5_0004);
        step(); chk("seq_addr8", imem_addr, 32'h8);

        // three wait cycles at 0x8
        imem_ready = 1'b0;
        step(); step(); step();
        chk("wait_addr8", imem_addr, 32'h8);
        chk("wait_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1;
        step(); chk("wait_valid", 32'(instr_valid), 32'd1); chk("wait_instr", instr_out, 32'hA5A5_0008);
        step(); step(); step(); step();
        chk("hold10_instr", instr_out, 32'hA5A5_0010);

        // stall with a branch latched in the second stall cycle
        stall = 1'b1;
        step(); branch_taken = 1'b1; branch_target = 32'h40;
        step(); branch_taken = 1'b0; branch_target = 32'h0;
        step(); step();
        chk("stall_instr", instr_out, 32'hA5A5_0010);
        chk("stall_pc", pc_out, 32'h10);
        stall = 1'b0;
        step(); chk("pend_addr", imem_addr, 32'h40);
        step();

        // jump and branch in the same cycle; jump wins
        jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h100;
        step(); chk("jmp_addr", imem_addr, 32'h200);
        // while no instruction is valid, redirects must be ignored
        imem_ready = 1'b0;
        step(); chk("ign_addr", imem_addr, 32'h200);
        imem_ready = 1'b1;
        step(); jump = 1'b0; branch_taken = 1'b0;
        step(); chk("ign_next", imem_addr, 32'h204);
        step();

        // a fresh redirect in the release cycle overrides the pending one
        stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
        step(); jump = 1'b0; stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
        step(); branch_taken = 1'b0; chk("fresh_addr", imem_addr, 32'h500);
        step();

        // misaligned jump target
        jump = 1'b1; jump_target = 32'h203;
        step(); jump = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_addr", imem_addr, 32'h80);
        chk("mis_err1", 32'(misalign_err), 32'd1);
        step(); chk("mis_err0", 32'(misalign_err), 32'd0);
`else
        chk("mis_addr", imem_addr, 32'h200);
        step();
`endif
        step(); chk("pre_rst_req", 32'(imem_req), 32'd1);

        // assert reset in the middle of a request
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_pc", pc_out, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("arst_err", 32'(misalign_err), 32'd0);
`endif
        step();
        reset = 1'b0;
        #1;
        chk("rel_idle_req", 32'(imem_req), 32'd0);
        step(); chk("rel_addr", imem_addr, 32'h0); chk("rel_req", 32'(imem_req), 32'd1);
        step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
